// File: rtl/wb_master_arbiter.sv
// Two-master to one-slave Wishbone arbiter: fixed priority to m0 with a starvation limit
// for m1, plus a watchdog that aborts slave cycles that never acknowledge.
module wb_master_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned SW        = 4,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_data_i,
  input  logic [SW-1:0] m0_sel_i,
  output logic [DW-1:0] m0_data_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,

  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_data_i,
  input  logic [SW-1:0] m1_sel_i,
  output logic [DW-1:0] m1_data_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,

  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] s_data_o,
  output logic [SW-1:0] s_sel_o,
  input  logic [DW-1:0] s_data_i,
  input  logic          s_ack_i,

  output logic [1:0]    gnt_o
);

  localparam int unsigned StarveW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam int unsigned WdW     = $clog2(TIMEOUT);

  localparam logic [StarveW-1:0] StarveMax = StarveW'(MAX_BURST);
  localparam logic [WdW-1:0]     WdLimit   = WdW'(TIMEOUT - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGnt0  = 2'd1;
  localparam logic [1:0] StGnt1  = 2'd2;
  localparam logic [1:0] StAbort = 2'd3;

  localparam logic [1:0] GntNone = 2'b00;
  localparam logic [1:0] GntM0   = 2'b01;
  localparam logic [1:0] GntM1   = 2'b10;

  logic [1:0]         state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;
  logic [WdW-1:0]     wd_cnt_q, wd_cnt_d;
  logic               abort_m1_q, abort_m1_d;

  logic req0, req1;
  logic m1_starved;
  logic wd_hit;

  assign req0       = m0_cyc_i & m0_stb_i;
  assign req1       = m1_cyc_i & m1_stb_i;
  assign m1_starved = req1 & (starve_cnt_q == StarveMax);

  // Slave-side and master-side muxing follows the registered grant only.
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_data_o  = '0;
    s_sel_o   = '0;
    m0_data_o = '0;
    m0_ack_o  = 1'b0;
    m1_data_o = '0;
    m1_ack_o  = 1'b0;
    unique case (gnt_q)
      GntM0: begin
        s_cyc_o   = m0_cyc_i;
        s_stb_o   = m0_stb_i;
        s_we_o    = m0_we_i;
        s_addr_o  = m0_addr_i;
        s_data_o  = m0_data_i;
        s_sel_o   = m0_sel_i;
        m0_data_o = s_data_i;
        m0_ack_o  = s_ack_i;
      end
      GntM1: begin
        s_cyc_o   = m1_cyc_i;
        s_stb_o   = m1_stb_i;
        s_we_o    = m1_we_i;
        s_addr_o  = m1_addr_i;
        s_data_o  = m1_data_i;
        s_sel_o   = m1_sel_i;
        m1_data_o = s_data_i;
        m1_ack_o  = s_ack_i;
      end
      default: ;
    endcase
  end

  // An ack on the limit cycle suppresses the abort.
  assign wd_hit   = s_stb_o & ~s_ack_i & (wd_cnt_q == WdLimit);
  assign m0_err_o = wd_hit & gnt_q[0];
  assign m1_err_o = wd_hit & gnt_q[1];
  assign gnt_o    = gnt_q;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    starve_cnt_d = starve_cnt_q;
    wd_cnt_d     = wd_cnt_q;
    abort_m1_d   = abort_m1_q;
    case (state_q)
      StIdle: begin
        wd_cnt_d = '0;
        if (req0 && !m1_starved) begin
          state_d = StGnt0;
          gnt_d   = GntM0;
          // Reaching here with req1 set implies the counter is below its limit.
          if (req1) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else if (req1) begin
          state_d      = StGnt1;
          gnt_d        = GntM1;
          starve_cnt_d = '0;
        end
      end
      StGnt0, StGnt1: begin
        if (wd_hit) begin
          state_d    = StAbort;
          gnt_d      = GntNone;
          abort_m1_d = gnt_q[1];
          wd_cnt_d   = '0;
        end else begin
          if (s_ack_i) begin
            wd_cnt_d = '0;
          end else if (s_stb_o) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
          if (!s_cyc_o) begin
            state_d = StIdle;
            gnt_d   = GntNone;
          end
        end
      end
      StAbort: begin
        if (abort_m1_q ? !m1_cyc_i : !m0_cyc_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = GntNone;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      gnt_q        <= GntNone;
      starve_cnt_q <= '0;
      wd_cnt_q     <= '0;
      abort_m1_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      starve_cnt_q <= starve_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
      abort_m1_q   <= abort_m1_d;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized run checked against an ownership-based reference model.
module tb_wb_master_arbiter;

  localparam int unsigned AW       = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned SW       = 4;
  localparam int unsigned MaxBurst = 4;
  localparam int unsigned Timeout  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [AW-1:0] m0_addr_i;
  logic [DW-1:0] m0_data_i;
  logic [SW-1:0] m0_sel_i;
  logic [DW-1:0] m0_data_o;
  logic          m0_ack_o, m0_err_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m1_addr_i;
  logic [DW-1:0] m1_data_i;
  logic [SW-1:0] m1_sel_i;
  logic [DW-1:0] m1_data_o;
  logic          m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_data_o;
  logic [SW-1:0] s_sel_o;
  logic [DW-1:0] s_data_i;
  logic          s_ack_i;
  logic [1:0]    gnt_o;

  always #5 clk = ~clk;

  wb_master_arbiter #(
    .AW        (AW),
    .DW        (DW),
    .SW        (SW),
    .MAX_BURST (MaxBurst),
    .TIMEOUT   (Timeout)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_cyc_i  (m0_cyc_i),
    .m0_stb_i  (m0_stb_i),
    .m0_we_i   (m0_we_i),
    .m0_addr_i (m0_addr_i),
    .m0_data_i (m0_data_i),
    .m0_sel_i  (m0_sel_i),
    .m0_data_o (m0_data_o),
    .m0_ack_o  (m0_ack_o),
    .m0_err_o  (m0_err_o),
    .m1_cyc_i  (m1_cyc_i),
    .m1_stb_i  (m1_stb_i),
    .m1_we_i   (m1_we_i),
    .m1_addr_i (m1_addr_i),
    .m1_data_i (m1_data_i),
    .m1_sel_i  (m1_sel_i),
    .m1_data_o (m1_data_o),
    .m1_ack_o  (m1_ack_o),
    .m1_err_o  (m1_err_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_addr_o  (s_addr_o),
    .s_data_o  (s_data_o),
    .s_sel_o   (s_sel_o),
    .s_data_i  (s_data_i),
    .s_ack_i   (s_ack_i),
    .gnt_o     (gnt_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic c0, input logic s0, input logic c1, input logic s1,
                       input logic ack);
    m0_cyc_i = c0;
    m0_stb_i = s0;
    m1_cyc_i = c1;
    m1_stb_i = s1;
    s_ack_i  = ack;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       c0, s0, c1, s1, ack;
    logic [1:0] gnt;
    logic       scyc, a0, a1, e0;
  } vec_t;

  vec_t vecs[$];

  // in = {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack}, out = {gnt[1:0], s_cyc, m0_ack, m1_ack, m0_err}
  function automatic vec_t mk(input logic [4:0] in, input logic [5:0] out);
    vec_t v;
    {v.c0, v.s0, v.c1, v.s1, v.ack} = in;
    {v.gnt, v.scyc, v.a0, v.a1, v.e0} = out;
    return v;
  endfunction

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;
  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'h2222_0000;
  localparam logic [31:0] Rd = 32'hDEAD_BEEF;

  // Reference model: who owns the bus, plus abort bookkeeping and counters.
  int owner, ab_by, starve, wd;
  bit aborting;

  initial begin
    vec_t v;
    int   n_gnt0, first_gnt1;
    logic [1:0] prev_gnt;
    int   own;
    logic e_cyc, e_stb, e_we, e_ack0, e_ack1, e_err0, e_err1, hit, g_cyc;
    logic [31:0] e_addr, e_data, e_d0, e_d1;
    logic [3:0]  e_sel;

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    m0_we_i = 1'b0; m0_addr_i = A0; m0_data_i = D0; m0_sel_i = 4'hF;
    m1_we_i = 1'b0; m1_addr_i = A1; m1_data_i = D1; m1_sel_i = 4'h3;
    s_data_i = Rd;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Single m0 read, slave acks two cycles after s_cyc rises
    vecs.push_back(mk(5'b11000, 6'b000000));
    vecs.push_back(mk(5'b11000, 6'b011000));
    vecs.push_back(mk(5'b11000, 6'b011000));
    vecs.push_back(mk(5'b11001, 6'b011100));
    vecs.push_back(mk(5'b00000, 6'b010000));
    vecs.push_back(mk(5'b00000, 6'b000000));
    // Simultaneous requests: m0 first, m1 after one idle turnaround
    vecs.push_back(mk(5'b11110, 6'b000000));
    vecs.push_back(mk(5'b11110, 6'b011000));
    vecs.push_back(mk(5'b11111, 6'b011100));
    vecs.push_back(mk(5'b00110, 6'b010000));
    vecs.push_back(mk(5'b00110, 6'b000000));
    vecs.push_back(mk(5'b00110, 6'b101000));
    vecs.push_back(mk(5'b00111, 6'b101010));
    vecs.push_back(mk(5'b00000, 6'b100000));
    vecs.push_back(mk(5'b00000, 6'b000000));
    // Ack lands exactly on the watchdog limit cycle
    vecs.push_back(mk(5'b11000, 6'b000000));
    for (int i = 0; i < int'(Timeout) - 1; i++) vecs.push_back(mk(5'b11000, 6'b011000));
    vecs.push_back(mk(5'b11001, 6'b011100));
    vecs.push_back(mk(5'b00000, 6'b010000));
    vecs.push_back(mk(5'b00000, 6'b000000));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.c0, v.s0, v.c1, v.s1, v.ack);
      @(negedge clk);
      e_addr = (v.gnt == 2'b01) ? A0 : (v.gnt == 2'b10) ? A1 : 32'h0;
      e_d0   = (v.gnt == 2'b01) ? Rd : 32'h0;
      e_d1   = (v.gnt == 2'b10) ? Rd : 32'h0;
      chk($sformatf("vec%0d gnt", i), 32'(gnt_o), 32'(v.gnt));
      chk($sformatf("vec%0d s_cyc", i), 32'(s_cyc_o), 32'(v.scyc));
      chk($sformatf("vec%0d m0_ack", i), 32'(m0_ack_o), 32'(v.a0));
      chk($sformatf("vec%0d m1_ack", i), 32'(m1_ack_o), 32'(v.a1));
      chk($sformatf("vec%0d m0_err", i), 32'(m0_err_o), 32'(v.e0));
      chk($sformatf("vec%0d s_addr", i), s_addr_o, e_addr);
      chk($sformatf("vec%0d m0_data", i), m0_data_o, e_d0);
      chk($sformatf("vec%0d m1_data", i), m1_data_o, e_d1);
      tick();
    end

    // Reset asserted during an active m0 write
    m0_we_i = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    chk("rst pre gnt", 32'(gnt_o), 32'h1);
    chk("rst pre s_we", 32'(s_we_o), 32'h1);
    tick();
    rst = 1'b0;
    s_ack_i = 1'b1;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst gnt", 32'(gnt_o), 32'h0);
    chk("rst s_cyc", 32'(s_cyc_o), 32'h0);
    chk("rst s_stb", 32'(s_stb_o), 32'h0);
    chk("rst s_we", 32'(s_we_o), 32'h0);
    chk("rst s_addr", s_addr_o, 32'h0);
    chk("rst s_data", s_data_o, 32'h0);
    chk("rst m0_ack", 32'(m0_ack_o), 32'h0);
    chk("rst m0_err", 32'(m0_err_o), 32'h0);
    chk("rst m0_data", m0_data_o, 32'h0);
    tick();
    @(negedge clk);
    chk("rst regrant", 32'(gnt_o), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    m0_we_i = 1'b0;
    repeat (2) tick();

    // m0 back-to-back while m1 waits: starvation limit hands over after MAX_BURST grants
    n_gnt0 = 0;
    first_gnt1 = -1;
    prev_gnt = 2'b00;
    for (int k = 0; k < 15; k++) begin
      drive((k % 3) != 2, (k % 3) != 2, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      if (gnt_o == 2'b01 && prev_gnt != 2'b01) n_gnt0++;
      if (gnt_o == 2'b10 && first_gnt1 < 0) first_gnt1 = k;
      prev_gnt = gnt_o;
      tick();
    end
    chk("burst m0 grants", 32'(n_gnt0), 32'd4);
    chk("burst m1 grant cycle", 32'(first_gnt1), 32'd13);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Slave never acks: err on the TIMEOUT-th strobe cycle, abort until m0 drops cyc
    for (int k = 0; k < 15; k++) begin
      drive(k < 12, k < 12, k >= 9, k >= 9, k >= 9);
      @(negedge clk);
      if (k == 0 || (k >= 9 && k <= 13)) begin
        chk($sformatf("to%0d gnt", k), 32'(gnt_o), 32'h0);
        chk($sformatf("to%0d s_cyc", k), 32'(s_cyc_o), 32'h0);
        chk($sformatf("to%0d acks", k), 32'({m1_ack_o, m0_ack_o}), 32'h0);
      end else if (k == 14) begin
        chk("to14 gnt", 32'(gnt_o), 32'h2);
      end else begin
        chk($sformatf("to%0d gnt", k), 32'(gnt_o), 32'h1);
        chk($sformatf("to%0d s_stb", k), 32'(s_stb_o), 32'h1);
      end
      chk($sformatf("to%0d m0_err", k), 32'(m0_err_o), 32'(k == 8));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Randomized run against the reference model
    rst = 1'b0;
    tick();
    rst = 1'b1;
    owner = -1; aborting = 1'b0; ab_by = 0; starve = 0; wd = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) m0_cyc_i = ~m0_cyc_i;
      if ($urandom_range(0, 3) == 0) m1_cyc_i = ~m1_cyc_i;
      m0_stb_i  = m0_cyc_i & ($urandom_range(0, 3) != 0);
      m1_stb_i  = m1_cyc_i & ($urandom_range(0, 3) != 0);
      s_ack_i   = ($urandom_range(0, 5) == 0);
      rst       = ($urandom_range(0, 149) != 0);
      m0_we_i   = 1'($urandom());
      m1_we_i   = 1'($urandom());
      m0_addr_i = $urandom();
      m1_addr_i = $urandom();
      m0_data_i = $urandom();
      m1_data_i = $urandom();
      m0_sel_i  = 4'($urandom());
      m1_sel_i  = 4'($urandom());
      s_data_i  = $urandom();
      @(negedge clk);
      own = aborting ? -1 : owner;
      e_cyc = 0; e_stb = 0; e_we = 0; e_addr = 0; e_data = 0; e_sel = 0;
      e_ack0 = 0; e_ack1 = 0; e_d0 = 0; e_d1 = 0;
      if (own == 0) begin
        e_cyc = m0_cyc_i; e_stb = m0_stb_i; e_we = m0_we_i; e_addr = m0_addr_i;
        e_data = m0_data_i; e_sel = m0_sel_i; e_ack0 = s_ack_i; e_d0 = s_data_i;
      end else if (own == 1) begin
        e_cyc = m1_cyc_i; e_stb = m1_stb_i; e_we = m1_we_i; e_addr = m1_addr_i;
        e_data = m1_data_i; e_sel = m1_sel_i; e_ack1 = s_ack_i; e_d1 = s_data_i;
      end
      g_cyc  = e_cyc;
      hit    = (own >= 0) && e_stb && !s_ack_i && (wd == int'(Timeout) - 1);
      e_err0 = hit && own == 0;
      e_err1 = hit && own == 1;
      chk("rnd gnt", 32'(gnt_o), (own == 0) ? 32'h1 : (own == 1) ? 32'h2 : 32'h0);
      chk("rnd s_cyc", 32'(s_cyc_o), 32'(e_cyc));
      chk("rnd s_stb", 32'(s_stb_o), 32'(e_stb));
      chk("rnd s_we", 32'(s_we_o), 32'(e_we));
      chk("rnd s_addr", s_addr_o, e_addr);
      chk("rnd s_data", s_data_o, e_data);
      chk("rnd s_sel", 32'(s_sel_o), 32'(e_sel));
      chk("rnd m0_ack", 32'(m0_ack_o), 32'(e_ack0));
      chk("rnd m1_ack", 32'(m1_ack_o), 32'(e_ack1));
      chk("rnd m0_err", 32'(m0_err_o), 32'(e_err0));
      chk("rnd m1_err", 32'(m1_err_o), 32'(e_err1));
      chk("rnd m0_data", m0_data_o, e_d0);
      chk("rnd m1_data", m1_data_o, e_d1);
      @(posedge clk);
      if (!rst) begin
        owner = -1; aborting = 1'b0; starve = 0; wd = 0;
      end else if (aborting) begin
        if (!(ab_by == 1 ? m1_cyc_i : m0_cyc_i)) aborting = 1'b0;
      end else if (owner < 0) begin
        if ((m0_cyc_i && m0_stb_i) &&
            !((m1_cyc_i && m1_stb_i) && starve == int'(MaxBurst))) begin
          owner = 0;
          wd = 0;
          if ((m1_cyc_i && m1_stb_i) && starve < int'(MaxBurst)) starve++;
        end else if (m1_cyc_i && m1_stb_i) begin
          owner = 1;
          wd = 0;
          starve = 0;
        end
      end else if (hit) begin
        aborting = 1'b1;
        ab_by = owner;
        owner = -1;
      end else begin
        if (s_ack_i) wd = 0;
        else if (e_stb) wd++;
        if (!g_cyc) owner = -1;
      end
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
